seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Multiplexed 4-digit display scanner feeding the hex-to-7-segment decoder (`hex7seg`). Holds a 16-bit display value, time-multiplexes it one nibble at a time onto a shared `hex` bus, and drives active-low digit anodes with a dead interval between digits to suppress ghosting. Value updates are frame-synchronous, so a frame never mixes two values. Optional leading-zero suppression.

## Interface
- `REFRESH_DIV`, 50000: clock cycles each digit is lit (SHOW slot); legal range ≥1.
- `DEAD_CYC`, 500: clock cycles all anodes are off after each SHOW slot; legal range ≥1.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `value` in 16: display value; `[3:0]` is digit 0 (rightmost), `[15:12]` is digit 3.
- `load` in 1: single-cycle strobe; captures `value` into the pending register.
- `lz_en` in 1: leading-zero suppression enable; sampled every cycle.
- `en` in 1: scan enable.
- `anode` out 4: digit enables, active-low, at most one bit low.
- `hex` out 4: nibble of the current digit; goes to `hex7seg`.
- `frame_done` out 1: one-cycle pulse at the end of each completed frame.

## Operation
- Registers:
  - `pending`[16], `pend_v`: capture register and its valid flag.
  - `active`[16]: the value currently shown.
  - `idx`[2]: current digit.
  - `cnt`: slot down-counter, wide enough for max(`REFRESH_DIV`, `DEAD_CYC`).
  - `state`: IDLE / SHOW / DEAD.
- `load`=1 sets `pending`←`value` and `pend_v`←1. This happens in any state.
- Commit: `active`←`pending` and `pend_v`←0. A commit happens only:
  - on leaving IDLE, or
  - at the end of DEAD with `idx`=3.
- `load` and commit in the same cycle: `active` takes the old `pending`. The new `value` goes into `pending` and `pend_v` stays 1, so the new value appears next frame.
- If `pend_v`=0 at a commit point, `active` is unchanged.
- IDLE:
  - `anode`=4'b1111.
  - If `en`=1: commit, set `idx`=0, `cnt`=`REFRESH_DIV`-1, go to SHOW.
- SHOW:
  - `hex`=`active[4*idx+3:4*idx]`.
  - `anode[idx]`=0 unless digit `idx` is blanked.
  - When `cnt`=0: go to DEAD, `cnt`=`DEAD_CYC`-1. Otherwise decrement `cnt`.
- DEAD:
  - `anode`=4'b1111; `hex` holds.
  - When `cnt`=0: `idx`←`idx`+1 (mod 4), `cnt`=`REFRESH_DIV`-1, go to SHOW.
  - If leaving with `idx`=3: also pulse `frame_done` and commit.
- Blanking applies only when `lz_en`=1, on `active` nibbles N3..N0:
  - digit 3 blanked if N3=0;
  - digit 2 blanked if N3=N2=0;
  - digit 1 blanked if N3=N2=N1=0;
  - digit 0 is never blanked.
- `en`=0 in any state: the next state is IDLE, `anode`=4'b1111 next cycle, and `idx`/`cnt` are discarded. Re-enabling always restarts at digit 0.

## Timing
- All outputs are registered and change one cycle after the state/counter condition.
- Reset values:
  - `anode`=4'b1111, `hex`=4'h0, `frame_done`=0;
  - `state`=IDLE, `idx`=0, `cnt`=0;
  - `active`=`pending`=16'h0, `pend_v`=0.
- Reset asserted mid-frame: outputs take their reset values immediately (asynchronously). A pending load is lost.
- Latency:
  - `en` rising to first anode low: 2 cycles (IDLE→SHOW transition, then registered output).
  - Frame length: 4·(`REFRESH_DIV`+`DEAD_CYC`) cycles.
  - A `load` appears on the display at the next frame boundary, at most one frame plus 1 cycle later.
- `frame_done` is high in the same cycle that `anode` shows digit 0 of the new frame.

## Structure
- Shared package `seg_pkg`:
  - `N_DIG`=4;
  - state type with encoding IDLE=2'd0, SHOW=2'd1, DEAD=2'd2;
  - `ANODE_OFF`=4'b1111.
- One combinational sub-module, `lz_blank`: 16-bit value plus `lz_en` in, 4-bit blank mask out.
- `hex7seg` is instantiated by the integrating top, not inside this block.

## Test plan
Parameters `REFRESH_DIV`=4 and `DEAD_CYC`=2 apply to all scenarios below.
- Reset, then `en`=1 with `load`/`value`=16'h1234 one cycle earlier:
  - `anode` sequence 1110×4, 1111×2, 1101×4, 1111×2, 1011×4, 1111×2, 0111×4, 1111×2;
  - `hex` 4,3,2,1;
  - `frame_done` pulses every 24 cycles.
- `load` 16'hABCD in mid-frame (during digit 1): the remainder of the frame still shows 16'h1234 digits; the next frame shows D,C,B,A.
- `load` asserted in the exact commit cycle with 16'h5555, with `pending`=16'h9999: the next frame shows 9999 and the following frame shows 5555.
- `lz_en`=1 with `value`=16'h0007: `anode` low only in the digit-0 slot (1110), and 1111 in all other slots. With 16'h0000, digit 0 still lights with `hex`=0.
- `en` dropped during digit 2 SHOW: `anode`=1111 the next cycle. Re-assert `en`: the scan restarts at digit 0 after 2 cycles.
- `rst_n` pulsed low during DEAD: `anode`=1111 and `hex`=0 immediately. After release with `en`=1, the display shows 0000.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and state type for the display scanner
package seg_pkg;
  localparam int N_DIG = 4;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  typedef enum logic [1:0] {IDLE = 2'd0, SHOW = 2'd1, DEAD = 2'd2} state_t;
endpackage

// File: rtl/seg_scan_ctrl_lz_blank.sv
// lz_blank: leading-zero blank mask, digit 0 always stays lit
module lz_blank (
  input  logic [15:0] value,
  input  logic        lz_en,
  output logic [3:0]  blank
);
  assign blank[3] = lz_en && (value[15:12] == 4'h0);
  assign blank[2] = lz_en && (value[15:8] == 8'h0);
  assign blank[1] = lz_en && (value[15:4] == 12'h0);
  assign blank[0] = 1'b0;
endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed scanner with dead time and frame-synchronous value updates
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_en,
  input  logic        en,
  output logic [3:0]  anode,
  output logic [3:0]  hex,
  output logic        frame_done
);
  localparam int MX = REFRESH_DIV > DEAD_CYC ? REFRESH_DIV : DEAD_CYC;
  localparam int CW = MX > 1 ? $clog2(MX) : 1;
  localparam logic [CW-1:0] SHOW_LD = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_LD = CW'(DEAD_CYC - 1);
  state_t state;
  logic [15:0] pending, active;
  logic pend_v, wrap, last, commit;
  logic [$clog2(N_DIG)-1:0] idx;
  logic [CW-1:0] cnt;
  logic [3:0] blank;
  lz_blank u_lz (.value(active), .lz_en, .blank);
  assign last = state == DEAD && cnt == '0 && idx == 2'(N_DIG - 1);
  assign commit = en && (state == IDLE || last);
  // Scan FSM, value capture/commit and registered display outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      cnt <= '0;
      pending <= 16'h0;
      active <= 16'h0;
      pend_v <= 1'b0;
      wrap <= 1'b0;
      anode <= ANODE_OFF;
      hex <= 4'h0;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        pending <= value;
        pend_v <= 1'b1;
      end else if (commit) pend_v <= 1'b0;
      if (commit && pend_v) active <= pending;
      wrap <= en && last;
      frame_done <= en && wrap;
      anode <= (en && state == SHOW && !blank[idx]) ? ~(4'b0001 << idx) : ANODE_OFF;
      if (state == SHOW) hex <= active[{idx, 2'b00} +: 4];
      if (!en) begin
        state <= IDLE;
        idx <= '0;
        cnt <= '0;
      end else if (state == IDLE) begin
        state <= SHOW;
        idx <= '0;
        cnt <= SHOW_LD;
      end else begin
        cnt <= cnt != '0 ? cnt - 1'b1 : state == SHOW ? DEAD_LD : SHOW_LD;
        if (cnt == '0) state <= state == SHOW ? DEAD : SHOW;
        if (cnt == '0 && state != SHOW) idx <= idx + 1'b1;
      end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for the display scanner (REFRESH_DIV=4, DEAD_CYC=2)
module tb_seg_scan_ctrl;
  typedef struct {
    logic [3:0] an;
    logic [3:0] hx;
    logic       fd;
  } exp_t;
  logic clk = 1'b0, rst_n, load, lz_en, en, frame_done, mon;
  logic [15:0] value;
  logic [3:0] anode, hex;
  int n_chk = 0, n_err = 0;
  exp_t q[$];
  exp_t e;
  seg_scan_ctrl #(.REFRESH_DIV(4), .DEAD_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lz_en(lz_en),
    .en(en), .anode(anode), .hex(hex), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  // one frame of per-cycle expectations: 4 lit cycles then 2 dark cycles per digit
  task automatic push_frame(logic [15:0] v, logic lz, logic first);
    for (int d = 0; d < 4; d++)
      for (int k = 0; k < 6; k++) begin
        exp_t x;
        x.an = (k >= 4 || (lz && d > 0 && (v >> (4 * d)) == 16'h0)) ? 4'b1111 : ~(4'b0001 << d);
        x.hx = 4'(v >> (4 * d));
        x.fd = !first && d == 0 && k == 0;
        q.push_back(x);
      end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain", 16'(q.size()), 16'd0);
    q.delete();
    mon = 1'b0;
  endtask
  task automatic pulse_load(logic [15:0] v);
    value = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask
  always @(posedge clk) begin
    #1;
    if (mon && q.size() > 0) begin
      e = q.pop_front();
      check("anode", 16'(anode), 16'(e.an));
      check("hex", 16'(hex), 16'(e.hx));
      check("frame_done", 16'(frame_done), 16'(e.fd));
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    rst_n = 1'b0; en = 1'b0; load = 1'b0; value = 16'h0; lz_en = 1'b0; mon = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_anode", 16'(anode), 16'hf);
    check("rst_hex", 16'(hex), 16'h0);
    check("rst_fd", 16'(frame_done), 16'h0);
    rst_n = 1'b1;
    pulse_load(16'h1234);
    push_frame(16'h1234, 1'b0, 1'b1);
    push_frame(16'hABCD, 1'b0, 1'b0);
    push_frame(16'h9999, 1'b0, 1'b0);
    push_frame(16'h5555, 1'b0, 1'b0);
    en = 1'b1;
    @(negedge clk);
    mon = 1'b1;
    repeat (7) @(negedge clk);
    pulse_load(16'hABCD);
    repeat (21) @(negedge clk);
    pulse_load(16'h9999);
    repeat (17) @(negedge clk);
    pulse_load(16'h5555);
    drain();
    en = 1'b0;
    repeat (2) @(negedge clk);
    lz_en = 1'b1;
    pulse_load(16'h0007);
    push_frame(16'h0007, 1'b1, 1'b1);
    push_frame(16'h0000, 1'b1, 1'b0);
    en = 1'b1;
    @(negedge clk);
    mon = 1'b1;
    repeat (9) @(negedge clk);
    pulse_load(16'h0000);
    drain();
    en = 1'b0;
    lz_en = 1'b0;
    repeat (2) @(negedge clk);
    pulse_load(16'h4321);
    en = 1'b1;
    repeat (14) @(posedge clk);
    #1;
    check("dig2_anode", 16'(anode), 16'hb);
    check("dig2_hex", 16'(hex), 16'h3);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_drop_anode", 16'(anode), 16'hf);
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    #1;
    check("restart_wait", 16'(anode), 16'hf);
    @(posedge clk);
    #1;
    check("restart_anode", 16'(anode), 16'he);
    check("restart_hex", 16'(hex), 16'h1);
    @(negedge clk);
    pulse_load(16'h7777);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_anode", 16'(anode), 16'hf);
    check("async_rst_hex", 16'(hex), 16'h0);
    check("async_rst_fd", 16'(frame_done), 16'h0);
    repeat (2) @(negedge clk);
    push_frame(16'h0000, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);
    mon = 1'b1;
    drain();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
